// File: rtl/tile_mem_arbiter.sv
// Shares the single-port tile RAM between display prefetch and game/clear writes,
// and maps fetched cell codes to rbg pixels. Optional faint grid overlay: GRID_LINES_EN.
module tile_mem_arbiter #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        wr_req,
  input  logic [10:0] wr_addr,
  input  logic [1:0]  wr_data,
  output logic        wr_ack,
  input  logic        clr_req,
  output logic        clr_busy,
  output logic [10:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_wdata,
  input  logic [1:0]  mem_rdata,
  output logic [11:0] rbg
);
  localparam logic [9:0]  H_ACT          = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT          = 10'(V_ACTIVE);
  localparam logic [9:0]  H_SLOT_B       = 10'(H_TOTAL - 3);
  localparam logic [9:0]  H_LAST         = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST         = 10'(V_TOTAL - 1);
  localparam logic [5:0]  LAST_FETCH_COL = 6'(GRID_W - 1);
  localparam logic [10:0] N_CELLS        = 11'(GRID_W * GRID_H);
  localparam logic [10:0] LAST_CELL      = 11'(GRID_W * GRID_H - 1);

  typedef enum logic {NORMAL, CLEAR} state_t;

  state_t      state;
  logic [10:0] clr_cnt;
  logic [1:0]  cur_cell;

  logic        slot_a, slot_b, fetch_b, active, grant_ok, load_cell;
  logic [9:0]  v_next;
  logic [11:0] pix_p0;

  function automatic logic [10:0] cell_addr(input logic [5:0] row, input logic [5:0] col);
    logic [10:0] r;
    r = {5'd0, row};
    return (r << 5) + (r << 3) + {5'd0, col};
  endfunction

  function automatic logic [11:0] palette(input logic [1:0] code);
    case (code)
      2'd1:    return 12'h00F;
      2'd2:    return 12'hF00;
      2'd3:    return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  // Slot A prefetches the next cell of this line; slot B prefetches column 0 of the next line.
  assign active    = (h_count < H_ACT) && (v_count < V_ACT);
  assign slot_a    = (h_count < H_ACT) && (h_count[3:0] == 4'd13) &&
                     (h_count[9:4] < LAST_FETCH_COL);
  assign slot_b    = (h_count == H_SLOT_B);
  assign v_next    = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
  assign fetch_b   = slot_b && (v_next < V_ACT);
  assign grant_ok  = !slot_a && !slot_b && !mem_we && !wr_ack;
  assign load_cell = (h_count[3:0] == 4'hF) || (h_count == H_LAST);

  // Pixel stage p0: colour of the cell currently under the beam
  always_comb begin
    pix_p0 = palette(cur_cell);
`ifdef GRID_LINES_EN
    if (cur_cell == 2'd0 && (h_count[3:0] == 4'd0 || v_count[3:0] == 4'd0))
      pix_p0 = 12'h222;
`endif
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state     <= NORMAL;
      clr_cnt   <= '0;
      clr_busy  <= 1'b0;
      wr_ack    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cur_cell  <= '0;
      rbg       <= '0;
    end else begin
      wr_ack <= 1'b0;
      mem_we <= 1'b0;
      if (slot_a)
        mem_addr <= cell_addr(v_count[9:4], h_count[9:4] + 6'd1);
      else if (fetch_b)
        mem_addr <= cell_addr(v_next[9:4], 6'd0);

      case (state)
        NORMAL: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end else begin
            clr_busy <= 1'b0;
            if (wr_req && grant_ok) begin
              wr_ack    <= 1'b1;
              mem_addr  <= wr_addr;
              mem_wdata <= wr_data;
              mem_we    <= (wr_addr < N_CELLS);
            end
          end
        end
        CLEAR: begin
          // clr_busy stays high through the last write cycle and drops in NORMAL
          if (grant_ok) begin
            mem_addr  <= clr_cnt;
            mem_wdata <= 2'd0;
            mem_we    <= 1'b1;
            clr_cnt   <= clr_cnt + 11'd1;
            if (clr_cnt == LAST_CELL)
              state <= NORMAL;
          end
        end
        default: state <= NORMAL;
      endcase

      // Fetch stage: RAM data for the next cell lands here, two cycles after its slot
      if (load_cell)
        cur_cell <= mem_rdata;
      rbg <= active ? pix_p0 : 12'h000;
    end
  end
endmodule

// File: tb/tb_tile_mem_arbiter.sv
// Bench for tile_mem_arbiter: drives timing counters directly, models the tile RAM and
// keeps an expected grid to predict pixels, fetch addresses and write/clear traffic.
module tb_tile_mem_arbiter;
  logic        clk25 = 1'b0;
  logic        rst;
  logic [9:0]  h_count, v_count;
  logic        wr_req;
  logic [10:0] wr_addr;
  logic [1:0]  wr_data;
  logic        wr_ack;
  logic        clr_req;
  logic        clr_busy;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_wdata;
  logic [1:0]  mem_rdata;
  logic [11:0] rbg;

  always #20 clk25 = ~clk25;

  tile_mem_arbiter dut (
    .clk25(clk25), .rst(rst), .h_count(h_count), .v_count(v_count),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clr_req(clr_req), .clr_busy(clr_busy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rbg(rbg)
  );

  // Synchronous single-port RAM, one-cycle read latency
  logic [1:0] ram [2048];
  always @(posedge clk25) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         acks    = 0;
  int         clr_next = 0;
  bit         pix_chk = 1'b0;
  bit         prev_we = 1'b0;
  bit         prev_ack = 1'b0;
  logic [1:0] exp_grid [2048];
  int         wr_seen  [2048];

  task automatic chk(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int exp_pix(input int h, input int v);
    int c;
    if (h >= 640 || v >= 480) return 0;
    c = int'(exp_grid[(v / 16) * 40 + h / 16]);
`ifdef GRID_LINES_EN
    if (c == 0 && (h % 16 == 0 || v % 16 == 0)) return 'h222;
`endif
    case (c)
      1: return 'h00F;
      2: return 'hF00;
      3: return 'hFFF;
      default: return 0;
    endcase
  endfunction

  // One clock: check everything the DUT registered for the cycle that just ended, then advance counters
  task automatic tick();
    int h, v, vn;
    @(posedge clk25);
    #1;
    cyc++;
    h = int'(h_count);
    v = int'(v_count);
    if (!rst) begin
      if (pix_chk) chk("pixel", int'(rbg), exp_pix(h, v));
      if (h < 640 && h % 16 == 13 && h / 16 < 39) begin
        chk("fetchA_we", int'(mem_we), 0);
        chk("fetchA_addr", int'(mem_addr), (v / 16) * 40 + h / 16 + 1);
      end else if (h == 797) begin
        vn = (v == 524) ? 0 : v + 1;
        chk("fetchB_we", int'(mem_we), 0);
        if (vn < 480) chk("fetchB_addr", int'(mem_addr), (vn / 16) * 40);
      end
      if (wr_ack) begin
        chk("ack_req", int'(wr_req), 1);
        chk("ack_we", int'(mem_we), int'(wr_addr < 11'd1200));
        if (wr_addr < 11'd1200) begin
          chk("ack_addr", int'(mem_addr), int'(wr_addr));
          chk("ack_data", int'(mem_wdata), int'(wr_data));
          exp_grid[wr_addr] = wr_data;
        end
        wr_seen[wr_addr]++;
        acks++;
      end else if (mem_we) begin
        chk("clr_busy_w", int'(clr_busy), 1);
        chk("clr_addr", int'(mem_addr), clr_next);
        chk("clr_data", int'(mem_wdata), 0);
        exp_grid[mem_addr] = 2'd0;
        clr_next++;
      end
      if (clr_busy) chk("ack_in_clear", int'(wr_ack), 0);
      if (prev_we) chk("we_b2b", int'(mem_we), 0);
      if (prev_ack) chk("ack_b2b", int'(wr_ack), 0);
    end
    prev_we  = mem_we;
    prev_ack = wr_ack;
    if (h_count == 10'd799) begin
      h_count = 10'd0;
      v_count = (v_count == 10'd524) ? 10'd0 : v_count + 10'd1;
    end else begin
      h_count = h_count + 10'd1;
    end
  endtask

  task automatic goto_pos(input int v, input int h);
    v_count = 10'(v);
    h_count = 10'(h);
  endtask

  task automatic game_write(input logic [10:0] a, input logic [1:0] d);
    int a0, k;
    a0 = acks;
    k  = 0;
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    while (acks == a0 && k < 64) begin
      tick();
      k++;
    end
    chk("ack_wait", acks, a0 + 1);
    wr_req = 1'b0;
  endtask

  // Enter line v from the blanking of the line above so cur_cell is primed, then check it whole
  task automatic scan_line(input int v);
    pix_chk = 1'b1;
    goto_pos((v == 0) ? 524 : v - 1, 700);
    repeat (900) tick();
  endtask

  task automatic check_ram();
    for (int i = 0; i < 1200; i++) chk("ram_cell", int'(ram[i]), int'(exp_grid[i]));
  endtask

  initial begin
    int k, n, a0, prev_cyc, w0;
    for (int i = 0; i < 2048; i++) begin
      exp_grid[i] = 2'd0;
      wr_seen[i]  = 0;
    end
    rst = 1'b1; wr_req = 1'b1; wr_addr = 11'd9; wr_data = 2'd1; clr_req = 1'b0;
    goto_pos(100, 300);

    // Reset held mid-line with a request pending
    repeat (3) tick();
    chk("rst_rbg", int'(rbg), 0);
    chk("rst_ack", int'(wr_ack), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_busy", int'(clr_busy), 0);
    chk("rst_addr", int'(mem_addr), 0);
    rst = 1'b0; wr_req = 1'b0;

    // Clear sweep over active lines with an out-of-range write held alongside
    goto_pos(200, 0);
    pix_chk = 1'b0;
    clr_next = 0;
    a0 = acks;
    wr_addr = 11'd1200; wr_data = 2'd3; wr_req = 1'b1; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_start_busy", int'(clr_busy), 1);
    chk("clr_start_noack", int'(wr_ack), 0);
    k = 0;
    while (clr_busy === 1'b1 && k < 6000) begin
      tick();
      k++;
    end
    chk("clr_done", int'(clr_busy), 0);
    chk("clr_count", clr_next, 1200);
    k = 0;
    while (acks == a0 && k < 64) begin
      tick();
      k++;
    end
    chk("ack_after_clr", acks, a0 + 1);
    wr_req = 1'b0;
    repeat (4) tick();
    chk("clr_no_extra", clr_next, 1200);
    check_ram();
    scan_line(0);
    scan_line(16);
    scan_line(479);

    // Preload through the write port during vertical blanking, then scan
    goto_pos(500, 650);
    game_write(11'd0, 2'd1);
    game_write(11'd1, 2'd2);
    game_write(11'd40, 2'd3);
    game_write(11'd241, 2'd3);
    repeat (2) tick();
    scan_line(0);
    scan_line(15);
    scan_line(16);
    scan_line(100);
    scan_line(480);

    // Write request raised in a slot cycle of an active line
    pix_chk = 1'b0;
    goto_pos(100, 8);
    k = 0;
    while (h_count != 10'd13 && k < 16) begin
      tick();
      k++;
    end
    wr_addr = 11'd5; wr_data = 2'd2; wr_req = 1'b1;
    tick();
    chk("slot_noack", int'(wr_ack), 0);
    chk("slot_nowe", int'(mem_we), 0);
    tick();
    chk("conf_ack", int'(wr_ack), 1);
    chk("conf_we", int'(mem_we), 1);
    chk("conf_addr", int'(mem_addr), 5);
    wr_req = 1'b0;
    tick();
    pix_chk = 1'b1;
    repeat (630) tick();

    // Held request with fresh address after each ack, in horizontal blanking
    goto_pos(490, 650);
    wr_addr = 11'd100; wr_data = 2'd0; wr_req = 1'b1;
    a0 = acks; n = 0; k = 0; prev_cyc = 0;
    while (n < 8 && k < 64) begin
      tick();
      k++;
      if (acks != a0 + n) begin
        if (n > 0) chk("held_gap", cyc - prev_cyc, 2);
        prev_cyc = cyc;
        n++;
        wr_addr = 11'(100 + n);
        wr_data = 2'(n);
      end
    end
    wr_req = 1'b0;
    chk("held_count", n, 8);
    repeat (4) tick();
    for (int i = 100; i < 108; i++) chk("held_once", wr_seen[i], 1);

    // Random writes (some out of range) while slots fire, then verify RAM and pixels
    pix_chk = 1'b0;
    goto_pos(200, $urandom_range(0, 799));
    for (int i = 0; i < 150; i++) begin
      game_write(11'($urandom_range(0, 1299)), 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (2) tick();
    check_ram();
    for (int i = 0; i < 4; i++) scan_line($urandom_range(0, 479));

    // Reset in the middle of a clear sweep
    pix_chk = 1'b0;
    goto_pos(300, 0);
    clr_next = 0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    k = 0;
    while (clr_next < 300 && k < 2000) begin
      tick();
      k++;
    end
    chk("midclr_reached", clr_next, 300);
    rst = 1'b1;
    tick();
    chk("midclr_busy", int'(clr_busy), 0);
    chk("midclr_we", int'(mem_we), 0);
    rst = 1'b0;
    w0 = clr_next;
    repeat (400) tick();
    chk("midclr_no_resume", clr_next, w0);
    chk("midclr_busy_low", int'(clr_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_mem_arbiter.md
Name: tile_mem_arbiter

Overview:
- Shares the single-port snake-grid tile RAM between the VGA scan-out path and the game-logic writer.
- Display fetches are prefetched on fixed time slots derived from the timing generator's h/v counters; they always win.
- Game writes, or an internal clear sweep, use every other cycle.
- Converts each fetched cell code into the 12-bit rbg pixel consumed by the display block.

Parameters:
- GRID_W, 40, grid columns (cells of 16x16 px).
- GRID_H, 30, grid rows.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- H_TOTAL, 800, pixels per line including blanking.
- V_TOTAL, 525, lines per frame including blanking.

Ports:
- clk25  in  1  25 MHz pixel clock.
- rst  in  1  reset; synchronous, active-high.
- h_count  in  10  horizontal counter from the timing generator, 0..H_TOTAL-1.
- v_count  in  10  vertical counter, 0..V_TOTAL-1.
- wr_req  in  1  game write request; held, with wr_addr and wr_data stable, until wr_ack.
- wr_addr  in  11  cell index, row*GRID_W+col.
- wr_data  in  2  cell code: 0 empty, 1 snake, 2 food, 3 wall.
- wr_ack  out  1  one-cycle pulse; write accepted.
- clr_req  in  1  pulse; start full-grid clear to code 0.
- clr_busy  out  1  high while the clear sweep runs.
- mem_addr  out  11  RAM address, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_wdata  out  2  RAM write data, registered.
- mem_rdata  in  2  RAM read data; synchronous RAM, one-cycle latency.
- rbg  out  12  pixel colour, registered: [11:8] red, [7:4] blue, [3:0] green.

Behaviour:
- Reset values: mem_addr=0, mem_we=0, mem_wdata=0, wr_ack=0, clr_busy=0, rbg=0, cur_cell=0, clear counter=0, FSM=NORMAL. Reset mid-clear aborts the sweep; RAM is left partially cleared.
- Display slots, highest priority, read only (mem_we=0):
  - Slot A: h_count<H_ACTIVE, h_count[3:0]==13, (h_count>>4)<GRID_W-1. Fetch address row=v_count>>4, col=(h_count>>4)+1.
  - Slot B: h_count==H_TOTAL-3. Compute v_next = v_count==V_TOTAL-1 ? 0 : v_count+1. If v_next<V_ACTIVE, fetch row=v_next>>4, col=0.
  - Timing: the address is loaded at the edge ending the slot cycle; mem_rdata is valid two cycles after the slot; cur_cell<=mem_rdata at the edge ending h_count[3:0]==15 (or h_count==H_TOTAL-1).
  - Address arithmetic: 11-bit unsigned, row*40 formed as (row<<5)+(row<<3).
- Pixel output: each edge, rbg <= active ? palette(cur_cell) : 0, where active = h_count<H_ACTIVE && v_count<V_ACTIVE. rbg therefore lags h_count by one cycle.
- Palette: 0 -> 12'h000, 1 -> 12'h00F, 2 -> 12'hF00, 3 -> 12'hFFF.
- Write grant: only in non-slot cycles, and never in a cycle where wr_ack or a clear write is currently asserted. This gives at most one grant per two cycles and prevents double writes on a held request.
  - On grant: mem_addr<=wr_addr, mem_wdata<=wr_data, mem_we<=1, wr_ack<=1, all for exactly one cycle.
  - Out of range: wr_addr>=GRID_W*GRID_H is acked, but mem_we stays 0.
- FSM NORMAL:
  - Serves wr_req.
  - clr_req -> CLEAR: counter=0, clr_busy=1.
  - clr_req and wr_req in the same cycle: clear wins; the write waits.
- FSM CLEAR:
  - Writes code 0 to address counter in grant cycles; wr_req is not acked.
  - After address GRID_W*GRID_H-1 is written -> NORMAL; clr_busy falls the following edge.
  - clr_req in CLEAR is ignored.
- In non-slot cycles with no grant: mem_we=0, mem_addr holds its last value.

Optional Feature:
- Macro GRID_LINES_EN.
- Defined: an active pixel whose cur_cell==0 and whose h_count[3:0]==0 or v_count[3:0]==0 outputs 12'h222 (faint grid). Other codes are unchanged.
- Undefined: empty cells are 12'h000 everywhere.

Test Plan:
- Reset: hold rst 3 cycles mid-line -> rbg, wr_ack, mem_we, clr_busy all 0; mem_addr=0.
- Scan-out: preload cell 0=1, cell 1=2, cell 40=3; run one frame.
  - v=0: rbg=12'h00F for h 0..15 and 12'hF00 for h 16..31 (each seen one cycle later).
  - v=16: rbg=12'hFFF for h 0..15.
  - h>=640 or v>=480: rbg=0.
- Slot conflict: assert wr_req (addr 5, data 2) during h=13 of an active line -> no grant at that edge; mem_we=1, mem_addr=5, wr_ack=1 during h=15. The display read at h=14 is undisturbed.
- Held request: keep wr_req high with new addr/data after each ack during blanking -> wr_ack pulses every second cycle; no address written twice.
- Clear: pulse clr_req, also hold wr_req -> exactly 1200 mem_we pulses with mem_wdata=0, addresses 0..1199; wr_ack stays 0 until clr_busy falls; the next frame shows all rbg=0. Write addr 1200 afterwards -> acked, mem_we stays 0.
- Reset mid-clear: assert rst after 300 clear writes -> clr_busy=0 next edge; the sweep does not resume.
